if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch unit for the 5-stage RISC-V core. Owns the program counter, issues single-outstanding read requests on the instruction bus, and presents each returned instruction with its address to the IF/ID pipeline register for capture. Handles stall requests from ctrl and jump/branch redirects from EX, dropping stale responses so that only correct-path instructions reach decode.

## Interface
- ADDR_WIDTH, 32, PC and bus address width (`ADDR_WIDTH`)
- DATA_WIDTH, 32, instruction width (`DATA_WIDTH`)
- RESET_PC, 0, PC value loaded on reset
- NOP_INST, 32'h00000013, bubble instruction (`NOP`, addi x0,x0,0)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  6  ctrl stall vector; bit 0 = PC stage (`STOP`=1 / `NOSTOP`=0)
- jump_flag_i  in  1  redirect request from EX
- jump_addr_i  in  ADDR_WIDTH  redirect target
- ibus_req_o  out  1  read request
- ibus_addr_o  out  ADDR_WIDTH  request address (= pc_q)
- ibus_gnt_i  in  1  request accepted this cycle
- ibus_rvalid_i  in  1  read data valid
- ibus_rdata_i  in  DATA_WIDTH  read data
- inst_addr_o  out  ADDR_WIDTH  address to IF/ID
- inst_o  out  DATA_WIDTH  instruction to IF/ID

## Operation
- State: pc_q, inst_buf, FSM {IDLE, REQ, WAIT, HOLD, DISCARD}. Reset: pc_q=RESET_PC, inst_buf=NOP_INST, state=IDLE.
- Reset outputs: ibus_req_o=0, ibus_addr_o=RESET_PC, inst_o=NOP_INST, inst_addr_o=0.
- At most one outstanding request. ibus_req_o=1 only in REQ; ibus_addr_o=pc_q always.
- Jump: target taken as {jump_addr_i[ADDR_WIDTH-1:2],2'b00}. Jump overrides stall and all other transitions.
- IDLE: next state REQ, unconditionally.
- REQ: gnt & jump -> pc_q=target, DISCARD. gnt & !jump -> WAIT. !gnt & jump -> pc_q=target, stay REQ (address may change while ungranted). Otherwise stay.
- WAIT: rvalid & jump -> drop data, pc_q=target, REQ. rvalid & !jump & stall_i[0]=NOSTOP -> deliver rdata, pc_q=pc_q+4, REQ. rvalid & !jump & STOP -> inst_buf=rdata, HOLD. !rvalid & jump -> pc_q=target, DISCARD.
- HOLD: jump -> drop inst_buf, pc_q=target, REQ. NOSTOP -> deliver inst_buf, pc_q=pc_q+4, REQ. STOP -> stay.
- DISCARD: rvalid -> drop data, REQ. jump -> pc_q=target (stay, or go REQ if rvalid same cycle).
- Delivery (combinational): inst_o=rdata or inst_buf, inst_addr_o=pc_q. In every non-delivery cycle inst_o=NOP_INST, inst_addr_o=0 (IF/ID captures a bubble).
- pc_q+4 wraps modulo 2^ADDR_WIDTH.
- rvalid outside WAIT/DISCARD is ignored. The instruction bus is reset by the same rst_i, so no response survives reset.

## Timing
- First request: IDLE for one cycle after reset release; ibus_req_o rises after the next edge.
- Zero-wait bus (gnt with req, rvalid next cycle): one instruction per 2 cycles. Instruction appears on inst_o in the rvalid cycle; IF/ID captures it on that edge.
- Redirect: new target on ibus_addr_o the cycle after jump_flag_i (REQ/WAIT/HOLD). From DISCARD, only after the stale rvalid arrives.
- Stall of N cycles during WAIT/HOLD delays delivery by exactly N cycles. No instruction is lost or duplicated.
- Async reset mid-transaction: returns to IDLE immediately; outputs take reset values combinationally.

## Test plan
- Reset release, zero-wait memory returning addr-as-data: requests at 0,4,8,12 on alternate cycles; inst_o/inst_addr_o pairs (0,0),(4,4),(8,8); NOP between.
- gnt delayed 3 cycles at pc=0x10: ibus_req_o held high with addr 0x10 for 4 cycles; single delivery at 0x10.
- Jump to 0x103 while in WAIT at pc=0x20: stale rvalid data dropped; next request addr 0x100; first delivered inst_addr_o=0x100.
- stall_i[0]=STOP for 3 cycles as rvalid (data 0xDEADBEEF) arrives: HOLD; inst_o=NOP while stalled; 0xDEADBEEF delivered on the first NOSTOP cycle; pc advances once.
- Jump in the same cycle as gnt: enters DISCARD; req stays low until rvalid; that response is dropped; then req to target.
- Assert rst_i mid-WAIT at pc=0x40, then release: outputs reset at once; first request after release at RESET_PC; pc=0xFFFFFFFC+4 wraps to 0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC and keeps at most one read outstanding on the instruction bus.
// It hands correct-path instructions to IF/ID, and stale responses after a redirect are dropped.
module if_fetch #(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [5:0]            stall_i,
    input  logic                  jump_flag_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic                  ibus_req_o,
    output logic [ADDR_WIDTH-1:0] ibus_addr_o,
    input  logic                  ibus_gnt_i,
    input  logic                  ibus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] ibus_rdata_i,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic [DATA_WIDTH-1:0] inst_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        HOLD    = 3'd3,
        DISCARD = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   inst_buf_q, inst_buf_d;

    logic [ADDR_WIDTH-1:0]   jump_target_s;
    logic [ADDR_WIDTH-1:0]   pc_inc_s;
    logic                    stop_s;
    logic                    deliver_s;
    logic [DATA_WIDTH-1:0]   deliver_data_s;
    logic                    unused_s;

    assign jump_target_s = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign pc_inc_s      = pc_q + ADDR_WIDTH'(4);
    assign stop_s        = stall_i[0];
    assign unused_s      = ^{stall_i[5:1], jump_addr_i[1:0]};

    // Next-state, PC and delivery selection; a redirect wins over stall and every other transition.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_buf_d     = inst_buf_q;
        deliver_s      = 1'b0;
        deliver_data_s = NOP_INST;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (jump_flag_i) begin
                    pc_d = jump_target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            REQ: begin
                if (jump_flag_i) begin
                    pc_d = jump_target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (ibus_gnt_i) begin
                    state_d = jump_flag_i ? DISCARD : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (ibus_rvalid_i) begin
                    if (jump_flag_i) begin
                        pc_d    = jump_target_s;
                        state_d = REQ;
                    end else if (!stop_s) begin
                        deliver_s      = 1'b1;
                        deliver_data_s = ibus_rdata_i;
                        pc_d           = pc_inc_s;
                        state_d        = REQ;
                    end else begin
                        inst_buf_d = ibus_rdata_i;
                        state_d    = HOLD;
                    end
                end else if (jump_flag_i) begin
                    pc_d    = jump_target_s;
                    state_d = DISCARD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (jump_flag_i) begin
                    pc_d    = jump_target_s;
                    state_d = REQ;
                end else if (!stop_s) begin
                    deliver_s      = 1'b1;
                    deliver_data_s = inst_buf_q;
                    pc_d           = pc_inc_s;
                    state_d        = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            DISCARD: begin
                // The stale response must drain before a new request can go out.
                if (jump_flag_i) begin
                    pc_d = jump_target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (ibus_rvalid_i) begin
                    state_d = REQ;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and hold-buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inst_buf_q <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    assign ibus_req_o  = (state_q == REQ);
    assign ibus_addr_o = pc_q;
    assign inst_o      = deliver_s ? deliver_data_s : NOP_INST;
    assign inst_addr_o = deliver_s ? pc_q : {ADDR_WIDTH{1'b0}};

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: a bus model with random grant/latency, random stalls and redirects.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        jump;
    logic [31:0] jump_addr;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] inst_addr;
    logic [31:0] inst;

    int nvec = 0;
    int nerr = 0;
    int deliveries = 0;
    bit mon_en = 1'b0;

    logic [31:0] sb[$];
    logic [31:0] exp_pc;

    bit          pend;
    logic [31:0] paddr;
    int          lat;

    if_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .jump_flag_i(jump), .jump_addr_i(jump_addr),
        .ibus_req_o(req), .ibus_addr_o(addr), .ibus_gnt_i(gnt), .ibus_rvalid_i(rvalid),
        .ibus_rdata_i(rdata), .inst_addr_o(inst_addr), .inst_o(inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {2'b11, a[31:2]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_pc = RPC;
        pend   = 1'b0;
        lat    = 0;
    endtask

    // Monitor: every non-bubble output must be the oldest outstanding expected fetch.
    always @(negedge clk) begin
        #2;
        if (mon_en && !rst) begin
            if (inst === NOP) begin
                check("bubble_addr", inst_addr, 32'h0);
            end else begin
                check("deliver_nostop", {31'h0, stall[0]}, 32'h0);
                if (sb.size() == 0) begin
                    check("unexpected_delivery", inst_addr, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    check("inst_addr", inst_addr, e);
                    check("inst_data", inst, mem_data(e));
                    exp_pc = e + 32'd4;
                    deliveries++;
                end
            end
        end
    end

    // Drive one bus/control cycle, then update the bus model and push expectations on grant.
    task automatic drive_cycle(input bit allow_rand);
        bit rv;
        @(negedge clk);
        rv     = pend && (lat == 0);
        rvalid = rv;
        rdata  = rv ? mem_data(paddr) : $urandom;
        gnt    = req && ($urandom_range(0, 3) != 0);
        if (allow_rand) begin
            stall     = 6'($urandom);
            stall[0]  = ($urandom_range(0, 3) == 0);
            jump      = ($urandom_range(0, 19) == 0);
            jump_addr = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom_range(0, 4095));
        end else begin
            stall = 6'h0;
            jump  = 1'b0;
        end
        #1;
        if (rv) pend = 1'b0;
        else if (pend && lat > 0) lat--;
        if (req && gnt) begin
            pend  = 1'b1;
            paddr = addr;
            lat   = $urandom_range(0, 2);
        end
        if (jump) begin
            sb.delete();
            exp_pc = {jump_addr[31:2], 2'b00};
        end else if (req && gnt) begin
            check("req_addr", addr, exp_pc);
            sb.push_back(exp_pc);
        end
    endtask

    task automatic start_after_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_req", {31'h0, req}, 32'h0);
        @(negedge clk);
        #1;
        check("first_req", {31'h0, req}, 32'h1);
        check("first_addr", addr, RPC);
    endtask

    initial begin
        int drain_start;
        bit did_reset;
        did_reset = 1'b0;
        rst = 1'b1; stall = '0; jump = 1'b0; jump_addr = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", {31'h0, req}, 32'h0);
        check("rst_addr", addr, RPC);
        check("rst_inst", inst, NOP);
        check("rst_inst_addr", inst_addr, 32'h0);
        start_after_reset();
        mon_en = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            drive_cycle(1'b1);
            if (!did_reset && i > 300 && pend && lat > 0) begin
                did_reset = 1'b1;
                #2;
                rst = 1'b1;
                #1;
                check("async_rst_req", {31'h0, req}, 32'h0);
                check("async_rst_addr", addr, RPC);
                check("async_rst_inst", inst, NOP);
                check("async_rst_iaddr", inst_addr, 32'h0);
                gnt = 1'b0; rvalid = 1'b0; jump = 1'b0; stall = '0;
                model_reset();
                @(negedge clk);
                start_after_reset();
            end
        end

        drain_start = deliveries;
        for (int i = 0; i < 40; i++) drive_cycle(1'b0);
        check("drain_progress", {31'h0, (deliveries - drain_start) >= 5}, 32'h1);
        check("total_progress", {31'h0, deliveries >= 100}, 32'h1);
        check("did_async_reset", {31'h0, did_reset}, 32'h1);
        repeat (4) drive_cycle(1'b0);
        mon_en = 1'b0;
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
